// File: rtl/as2650_bus_pkg.sv
// Shared definitions for the external multiplexed address/data bus sequencer.
package as2650_bus_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        READ,
        WRITE,
        DONE
    } bus_state_t;

endpackage

// File: rtl/ext_bus_seq.sv
// Sequences one core access onto an 8-bit muxed pad bus: latch hi/lo address, strobe, turnaround.
// Latency accept->ack 4+WAIT_STATES (3+WAIT_STATES on hi-byte reuse); core holds req until ack.
module ext_bus_seq
    import as2650_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic        bus_dir,
    output logic        le_hi,
    output logic        le_lo,
    output logic        oe_n,
    output logic        we_n
);

    bus_state_t          state;
    logic                we_q;
    logic [15:0]         addr_q;
    logic [7:0]          wdata_q;
    logic [7:0]          hi_last;
    logic                hi_valid;
    logic [WAIT_W-1:0]   wait_cnt;

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hi_last  <= '0;
            hi_valid <= 1'b0;
            wait_cnt <= '0;
            ack      <= 1'b0;
            rdata    <= '0;
            bus_out  <= '0;
            bus_dir  <= 1'b1;
            le_hi    <= 1'b0;
            le_lo    <= 1'b0;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
        end else begin
            ack     <= 1'b0;
            bus_dir <= 1'b1;
            le_hi   <= 1'b0;
            le_lo   <= 1'b0;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        bus_dir <= 1'b0;
                        // The external high latch still holds this byte, so skip reloading it.
                        if (hi_valid && (addr[15:8] == hi_last)) begin
                            state   <= ADDR_LO;
                            le_lo   <= 1'b1;
                            bus_out <= addr[7:0];
                        end else begin
                            state   <= ADDR_HI;
                            le_hi   <= 1'b1;
                            bus_out <= addr[15:8];
                        end
                    end
                end
                ADDR_HI: begin
                    hi_last  <= addr_q[15:8];
                    hi_valid <= 1'b1;
                    state    <= ADDR_LO;
                    le_lo    <= 1'b1;
                    bus_dir  <= 1'b0;
                    bus_out  <= addr_q[7:0];
                end
                ADDR_LO: begin
                    wait_cnt <= WAIT_W'(WAIT_STATES);
                    if (we_q) begin
                        state   <= WRITE;
                        we_n    <= 1'b0;
                        bus_dir <= 1'b0;
                        bus_out <= wdata_q;
                    end else begin
                        state <= READ;
                        oe_n  <= 1'b0;
                    end
                end
                READ: begin
                    if (wait_cnt == '0) begin
                        rdata <= bus_in;
                        state <= DONE;
                        ack   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        oe_n     <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
                        ack   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        we_n     <= 1'b0;
                        bus_dir  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_seq.sv
// Directed and randomized access bench for ext_bus_seq with zero and three wait states.
module tb_ext_bus_seq;

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b1;
    logic        req      = 1'b0;
    logic        we       = 1'b0;
    logic [15:0] addr     = '0;
    logic [7:0]  wdata    = '0;
    logic [7:0]  bus_in   = '0;
    logic        sel      = 1'b0;

    logic        ack0, bus_dir0, le_hi0, le_lo0, oe_n0, we_n0;
    logic [7:0]  rdata0, bus_out0;
    logic        ack3, bus_dir3, le_hi3, le_lo3, oe_n3, we_n3;
    logic [7:0]  rdata3, bus_out3;
    logic        req0, req3;

    logic        o_ack, o_bus_dir, o_le_hi, o_le_lo, o_oe_n, o_we_n;
    logic [7:0]  o_rdata, o_bus_out;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit ack0_d = 1'b0;
    bit ack3_d = 1'b0;
    bit          hv [2];
    logic [7:0]  hl [2];

    always #5 wb_clk_i = ~wb_clk_i;

    assign req0 = req & ~sel;
    assign req3 = req & sel;

    assign o_ack     = sel ? ack3     : ack0;
    assign o_bus_dir = sel ? bus_dir3 : bus_dir0;
    assign o_le_hi   = sel ? le_hi3   : le_hi0;
    assign o_le_lo   = sel ? le_lo3   : le_lo0;
    assign o_oe_n    = sel ? oe_n3    : oe_n0;
    assign o_we_n    = sel ? we_n3    : we_n0;
    assign o_rdata   = sel ? rdata3   : rdata0;
    assign o_bus_out = sel ? bus_out3 : bus_out0;

    ext_bus_seq #(.WAIT_STATES(0)) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n), .req(req0), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack0), .rdata(rdata0), .bus_out(bus_out0), .bus_in(bus_in),
        .bus_dir(bus_dir0), .le_hi(le_hi0), .le_lo(le_lo0), .oe_n(oe_n0), .we_n(we_n0)
    );

    ext_bus_seq #(.WAIT_STATES(3)) dut3 (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n), .req(req3), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack3), .rdata(rdata3), .bus_out(bus_out3), .bus_in(bus_in),
        .bus_dir(bus_dir3), .le_hi(le_hi3), .le_lo(le_lo3), .oe_n(oe_n3), .we_n(we_n3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete access; inputs are scrambled after accept, req drops once ack is seen.
    task automatic access(input bit s, input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] bi, input bit exp_hi, input int waits);
        int lat = 0, hi_n = 0, lo_n = 0, rd_n = 0, wr_n = 0, dir_bad = 0;
        logic [7:0] hi_v = '0, lo_v = '0, wr_v = '0, rd_v = '0;
        @(negedge wb_clk_i);
        sel = s; req = 1'b1; we = wr; addr = a; wdata = d; bus_in = bi;
        for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
            @(negedge wb_clk_i);
            if (o_le_hi) begin hi_n++; hi_v = o_bus_out; end
            if (o_le_lo) begin lo_n++; lo_v = o_bus_out; end
            if (!o_oe_n) begin rd_n++; if (o_bus_dir !== 1'b1) dir_bad++; end
            if (!o_we_n) begin wr_n++; wr_v = o_bus_out; if (o_bus_dir !== 1'b0) dir_bad++; end
            if (o_ack) begin lat = cyc; rd_v = o_rdata; req = 1'b0; end
            if (cyc == 1) begin addr = ~a; wdata = ~d; we = ~wr; end
        end
        req = 1'b0;
        chk("latency", lat, (exp_hi ? 4 : 3) + waits);
        chk("le_hi_cycles", hi_n, exp_hi);
        if (exp_hi) chk("hi_byte", hi_v, a[15:8]);
        chk("le_lo_cycles", lo_n, 1);
        chk("lo_byte", lo_v, a[7:0]);
        chk("oe_cycles", rd_n, wr ? 0 : 1 + waits);
        chk("we_cycles", wr_n, wr ? 1 + waits : 0);
        chk("strobe_dir", dir_bad, 0);
        if (wr) chk("wr_data", wr_v, d);
        else    chk("rdata", rd_v, bi);
    endtask

    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            chk("excl0", (int'(le_hi0) + int'(le_lo0) + int'(!oe_n0) + int'(!we_n0)) <= 1, 1);
            chk("excl3", (int'(le_hi3) + int'(le_lo3) + int'(!oe_n3) + int'(!we_n3)) <= 1, 1);
            chk("ack_twice0", ack0 && ack0_d, 0);
            chk("ack_twice3", ack3 && ack3_d, 0);
            ack0_d = ack0;
            ack3_d = ack3;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bit seen;
        bit s, wr;
        logic [15:0] a;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_le_hi", le_hi0, 0);
        chk("rst_le_lo", le_lo0, 0);
        chk("rst_oe_n", oe_n0, 1);
        chk("rst_we_n", we_n0, 1);
        chk("rst_bus_dir", bus_dir0, 1);
        chk("rst_bus_out", bus_out0, 8'h00);
        chk("rst_ack", ack0, 0);
        chk("rst_rdata", rdata0, 8'h00);
        chk("rst3_oe_n", oe_n3, 1);
        chk("rst3_bus_dir", bus_dir3, 1);
        repeat (2) @(negedge wb_clk_i);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // First read after reset always loads the high latch
        access(0, 0, 16'h0000, 8'h00, 8'h04, 1, 0);
        // High byte 0x00 already latched: both reads skip le_hi
        access(0, 0, 16'h0010, 8'h00, 8'h91, 0, 0);
        access(0, 0, 16'h0011, 8'h00, 8'hE3, 0, 0);
        access(0, 1, 16'h01FE, 8'hC8, 8'h00, 1, 0);
        chk("rdata_hold_wr", rdata0, 8'hE3);
        access(0, 0, 16'h0200, 8'h00, 8'h6B, 1, 0);
        // Three wait states
        access(1, 0, 16'h1234, 8'h00, 8'h5A, 1, 3);
        access(1, 1, 16'h1256, 8'hA5, 8'h00, 0, 3);
        chk("rdata3_hold", rdata3, 8'h5A);

        // Reset in the middle of a read strobe
        @(negedge wb_clk_i);
        sel = 0; req = 1'b1; we = 1'b0; addr = 16'h0233; bus_in = 8'h77;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (!oe_n0) seen = 1'b1;
        end
        chk("abort_reached_read", seen, 1);
        #2 rst_n = 1'b0; req = 1'b0;
        #1;
        chk("abort_oe_n", oe_n0, 1);
        chk("abort_bus_dir", bus_dir0, 1);
        chk("abort_ack", ack0, 0);
        chk("abort_rdata", rdata0, 8'h00);
        #1 rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge wb_clk_i);
            if (ack0) acks++;
        end
        chk("abort_no_ack", acks, 0);
        access(0, 0, 16'h0233, 8'h00, 8'h3C, 1, 0);

        // Randomized accesses; bench tracks the latched high byte per instance
        @(negedge wb_clk_i);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        hv[0] = 1'b0; hv[1] = 1'b0; hl[0] = '0; hl[1] = '0;
        for (int k = 0; k < 24; k++) begin
            s  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = {8'($urandom_range(0, 2)), 8'($urandom)};
            access(s, wr, a, 8'($urandom), 8'($urandom),
                   !(hv[s] && hl[s] == a[15:8]), s ? 3 : 0);
            hv[s] = 1'b1;
            hl[s] = a[15:8];
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ext_bus_seq.md
EXT_BUS_SEQ -- requirements
Module: ext_bus_seq

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, range 0..7: extra oe_n/we_n low cycles per access.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  core requests a bus access; held until ack.
REQ-005 SHALL have port we  input  1  1 = write, 0 = read; sampled at accept.
REQ-006 SHALL have port addr  input  16  access address; sampled at accept.
REQ-007 SHALL have port wdata  input  8  write data; sampled at accept.
REQ-008 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  8  read data, valid from ack until next read completes.
REQ-010 SHALL have port bus_out  output  8  muxed address/data driven to pads.
REQ-011 SHALL have port bus_in  input  8  data from pads.
REQ-012 SHALL have port bus_dir  output  1  1 = pads input (tristate), 0 = driving bus_out.
REQ-013 SHALL have ports le_hi, le_lo  output  1 each  external address latch enables, latch closes on falling edge.
REQ-014 SHALL have ports oe_n, we_n  output  1 each  active-low memory read/write strobes.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR_HI, ADDR_LO, READ, WRITE, DONE; all outputs registered/decoded from registered state (Moore).
REQ-016 SHALL, in IDLE with req=1 at a clock edge, capture we/addr/wdata and move to ADDR_HI, or to ADDR_LO when hi_valid=1 and addr[15:8]==hi_last.
REQ-017 SHALL in ADDR_HI drive le_hi=1, bus_dir=0, bus_out=addr[15:8], set hi_last=addr[15:8], hi_valid=1; next state ADDR_LO.
REQ-018 SHALL in ADDR_LO drive le_lo=1, bus_dir=0, bus_out=addr[7:0]; next state READ (we=0) or WRITE (we=1).
REQ-019 SHALL in READ drive oe_n=0, bus_dir=1 for 1+WAIT_STATES cycles, capturing rdata<=bus_in on the final cycle's closing edge.
REQ-020 SHALL in WRITE drive we_n=0, bus_dir=0, bus_out=wdata for 1+WAIT_STATES cycles.
REQ-021 SHALL in DONE assert ack=1, bus_dir=1, all strobes inactive, ignore req; next state IDLE (bus turnaround cycle).
REQ-022 SHALL never assert more than one of le_hi, le_lo, !oe_n, !we_n in the same cycle.
REQ-023 SHALL give latency req-accept edge to ack: 4+WAIT_STATES cycles with ADDR_HI, 3+WAIT_STATES when skipped.
REQ-024 SHALL ignore changes on req/we/addr/wdata between accept and DONE.
REQ-025 SHALL hold bus_out at its last driven value while bus_dir=1.
REQ-026 SHALL use a 3-bit wait counter loaded with WAIT_STATES on entering READ/WRITE, decrementing to 0 then exiting.

Reset
REQ-027 SHALL on rst_n=0 immediately force: state IDLE, le_hi=0, le_lo=0, oe_n=1, we_n=1, bus_dir=1, bus_out=0, ack=0, rdata=0, hi_valid=0, hi_last=0, wait counter 0.
REQ-028 SHALL abort any in-flight access on reset with no ack; first access after reset always issues ADDR_HI.

Structure
REQ-029 SHALL take the FSM state enum and WAIT_W=3 constant from shared package as2650_bus_pkg.
REQ-030 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-031 Reset release, read addr=0x0000, bus_in=0x04 -> le_hi 1 cycle (bus_out 0x00), le_lo 1 cycle (0x00), oe_n low 1 cycle, ack in 4th cycle, rdata=0x04.
REQ-032 Back-to-back reads 0x0010 then 0x0011 -> second access skips le_hi, ack 3 cycles after accept.
REQ-033 Write addr=0x01FE, wdata=0xC8, then read 0x0200 -> write shows we_n low with bus_out=0xC8, bus_dir=0; read reissues le_hi with bus_out=0x02.
REQ-034 WAIT_STATES=3, read 0x1234, bus_in=0x5A -> oe_n low exactly 4 cycles, ack 7 cycles after accept, rdata=0x5A.
REQ-035 rst_n pulsed low during READ -> oe_n=1, bus_dir=1 asynchronously, no ack; next read of same high byte still emits le_hi.
REQ-036 Random-stimulus checker over all tests -> strobe mutual exclusion (REQ-022) never violated; ack never two consecutive cycles.
